// File: rtl/window_sequencer_pkg.sv
// Shared definitions for the window sequencer: FSM state encoding and default geometry.
package window_sequencer_pkg;

    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;
    localparam int unsigned DEF_CNT_WIDTH  = 10;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/window_sequencer_if.sv
// Pixel-stream / window-control bundle between the source, sequencer and line buffer.
// drop_cnt exists only when DROP_CNT_EN is defined.
interface window_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 10
);
    logic                 frame_start;
    logic                 pixel_valid;
    logic                 buf_shift_en;
    logic                 pixel_edge;
    logic                 window_valid;
    logic [CNT_WIDTH-1:0] win_col;
    logic [CNT_WIDTH-1:0] win_row;
    logic                 busy;
    logic                 frame_done;
`ifdef DROP_CNT_EN
    logic [15:0]          drop_cnt;
`endif

    modport master (
        output frame_start, pixel_valid,
        input  buf_shift_en, pixel_edge, window_valid, win_col, win_row, busy,
`ifdef DROP_CNT_EN
        input  drop_cnt,
`endif
        input  frame_done
    );

    modport slave (
        input  frame_start, pixel_valid,
        output buf_shift_en, pixel_edge, window_valid, win_col, win_row, busy,
`ifdef DROP_CNT_EN
        output drop_cnt,
`endif
        output frame_done
    );

endinterface

// File: rtl/window_sequencer_pix_counter.sv
// Column/row position counter with column wrap; clr_i forces the current position to (0,0)
// so a pixel arriving together with the clear is counted as the first pixel.
module pix_counter
    import window_sequencer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] col_o,
    output logic [CNT_WIDTH-1:0] row_o,
    output logic                 last_col_o
);
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);

    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;

    always_comb begin
        col_o      = clr_i ? '0 : col_q;
        row_o      = clr_i ? '0 : row_q;
        last_col_o = (col_o == COL_LAST);
        col_d      = col_o;
        row_d      = row_o;
        if (inc_i) begin
            if (last_col_o) begin
                col_d = '0;
                row_d = row_o + CNT_WIDTH'(1);
            end else begin
                col_d = col_o + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/window_sequencer.sv
// Sequences a raster pixel stream into 3x3 interior window strobes for a 3-line buffer.
// Define DROP_CNT_EN to add a saturating counter of pixels ignored outside a frame.
module window_sequencer
    import window_sequencer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    window_sequencer_if.slave seq
);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);

    seq_state_e           state_q, state_d;
    logic                 accept;
    logic [CNT_WIDTH-1:0] col, row;
    logic                 last_col;
    logic                 wv_q, wv_d;
    logic [CNT_WIDTH-1:0] win_col_q, win_col_d;
    logic [CNT_WIDTH-1:0] win_row_q, win_row_d;

    // frame_start opens the frame in the same cycle, so a coincident pixel is taken as (0,0)
    assign accept = seq.pixel_valid &&
                    (seq.frame_start || state_q == FILL || state_q == RUN);

    pix_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pix_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (seq.frame_start),
        .inc_i      (accept),
        .col_o      (col),
        .row_o      (row),
        .last_col_o (last_col)
    );

    always_comb begin
        state_d   = state_q;
        wv_d      = accept && (row >= TWO) && (col >= TWO);
        win_col_d = wv_d ? (col - ONE) : win_col_q;
        win_row_d = wv_d ? (row - ONE) : win_row_q;
        if (seq.frame_start) begin
            state_d = FILL;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                FILL: if (accept && last_col && row == ONE)      state_d = RUN;
                RUN:  if (accept && last_col && row == ROW_LAST) state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wv_q      <= 1'b0;
            win_col_q <= '0;
            win_row_q <= '0;
        end else begin
            state_q   <= state_d;
            wv_q      <= wv_d;
            win_col_q <= win_col_d;
            win_row_q <= win_row_d;
        end
    end

    assign seq.buf_shift_en = accept;
    assign seq.pixel_edge   = accept && (col == '0);
    assign seq.window_valid = wv_q;
    assign seq.win_col      = win_col_q;
    assign seq.win_row      = win_row_q;
    assign seq.busy         = (state_q == FILL) || (state_q == RUN);
    assign seq.frame_done   = (state_q == DONE);

`ifdef DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (seq.pixel_valid && !accept && drop_q != '1) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign seq.drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_window_sequencer.sv
// Scoreboard bench for window_sequencer at 8x4; DROP_CNT_EN enables the drop_cnt checks.
module tb_window_sequencer;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CW = 10;

    typedef struct {
        int cyc;
        int a;
        int b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    window_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .seq (bus)
    );

    exp_t shift_q[$];
    exp_t win_q[$];
    exp_t done_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int win_cnt  = 0;
    int done_cnt = 0;
    bit active   = 1'b0;
    int pos      = 0;
    int drops    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT strobe, or every expectation that has come due, is matched here
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.buf_shift_en || (shift_q.size() > 0 && shift_q[0].cyc <= cyc)) begin
                if (shift_q.size() == 0) check("unexpected_shift", cyc, -1);
                else begin
                    e = shift_q.pop_front();
                    check("shift_present", bus.buf_shift_en, 1);
                    check("shift_cycle", cyc, e.cyc);
                    check("pixel_edge", bus.pixel_edge, e.a);
                end
            end
            if (bus.window_valid) win_cnt++;
            if (bus.window_valid || (win_q.size() > 0 && win_q[0].cyc <= cyc)) begin
                if (win_q.size() == 0) check("unexpected_window", cyc, -1);
                else begin
                    e = win_q.pop_front();
                    check("window_present", bus.window_valid, 1);
                    check("window_cycle", cyc, e.cyc);
                    check("win_row", bus.win_row, e.a);
                    check("win_col", bus.win_col, e.b);
                end
            end
            if (bus.frame_done) done_cnt++;
            if (bus.frame_done || (done_q.size() > 0 && done_q[0].cyc <= cyc)) begin
                if (done_q.size() == 0) check("unexpected_frame_done", cyc, -1);
                else begin
                    e = done_q.pop_front();
                    check("frame_done_present", bus.frame_done, 1);
                    check("frame_done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Drive one cycle of input and queue what the DUT must present for it
    task automatic drive(input bit fs, input bit pv);
        exp_t e;
        int   r, c;
        @(posedge clk);
        #1;
        bus.frame_start = fs;
        bus.pixel_valid = pv;
        if (fs) begin
            active = 1'b1;
            pos    = 0;
        end
        if (pv && active) begin
            r = pos / W;
            c = pos % W;
            e.cyc = cyc; e.a = (c == 0) ? 1 : 0; e.b = 0;
            shift_q.push_back(e);
            if (r >= 2 && c >= 2) begin
                e.cyc = cyc + 1; e.a = r - 1; e.b = c - 1;
                win_q.push_back(e);
            end
            if (pos == W * H - 1) begin
                e.cyc = cyc + 1; e.a = 0; e.b = 0;
                done_q.push_back(e);
                active = 1'b0;
            end
            pos++;
        end else if (pv) begin
            drops++;
        end
    endtask

    task automatic frame_begin();
        win_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic frame_end(input int exp_windows, input int exp_done);
        repeat (3) drive(1'b0, 1'b0);
        check("windows_in_frame", win_cnt, exp_windows);
        check("frame_done_count", done_cnt, exp_done);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_window_valid"}, bus.window_valid, 0);
        check({tag, "_win_row"}, bus.win_row, 0);
        check({tag, "_win_col"}, bus.win_col, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_buf_shift_en"}, bus.buf_shift_en, 0);
`ifdef DROP_CNT_EN
        check({tag, "_drop_cnt"}, bus.drop_cnt, 0);
`endif
    endtask

    initial begin
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // pixels while IDLE are ignored
        repeat (5) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("idle_busy", bus.busy, 0);
`ifdef DROP_CNT_EN
        check("idle_drop_cnt", bus.drop_cnt, 5);
`endif

        // back-to-back frame: first window (1,1) one cycle after pixel 18
        frame_begin();
        drive(1'b1, 1'b0);
        repeat (32) drive(1'b0, 1'b1);
        frame_end(12, 1);

        // pixel_valid toggling 1010...
        frame_begin();
        drive(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) drive(1'b0, (i % 2) == 0);
        frame_end(12, 1);

        // frame restarted after 13 pixels
        frame_begin();
        drive(1'b1, 1'b0);
        repeat (13) drive(1'b0, 1'b1);
        check("abort_busy", bus.busy, 1);
        drive(1'b1, 1'b0);
        repeat (32) drive(1'b0, 1'b1);
        frame_end(12, 1);

        // frame_start together with the first pixel
        frame_begin();
        drive(1'b1, 1'b1);
        #1;
        check("fs_same_cycle_pixel_edge", bus.pixel_edge, 1);
        check("fs_same_cycle_shift", bus.buf_shift_en, 1);
        repeat (31) drive(1'b0, 1'b1);
        frame_end(12, 1);

        // reset after 20 pixels abandons the frame
        frame_begin();
        drive(1'b1, 1'b0);
        repeat (20) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("pre_reset_windows", win_cnt, 2);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        active = 1'b0;
        drops  = 0;
        #1;
        check_outputs_zero("midframe_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("post_reset_busy", bus.busy, 0);
`ifdef DROP_CNT_EN
        check("post_reset_drop_cnt", bus.drop_cnt, 4);
`endif
        frame_begin();
        drive(1'b1, 1'b0);
        repeat (32) drive(1'b0, 1'b1);
        frame_end(12, 1);

        check("shift_queue_drained", shift_q.size(), 0);
        check("window_queue_drained", win_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
`ifdef DROP_CNT_EN
        check("final_drop_cnt", bus.drop_cnt, drops);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_sequencer.md
WINDOW_SEQUENCER -- requirements
Module: window_sequencer

Interface
REQ-001 Parameter IMG_WIDTH, default 640: pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame.
REQ-003 Parameter CNT_WIDTH, default 10: width of the column and row counters; SHALL satisfy 2**CNT_WIDTH > max(IMG_WIDTH, IMG_HEIGHT).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse that starts or restarts a frame.
REQ-007 pixel_valid  input  1  grayscale pixel present this cycle, from RAW2GRAY.
REQ-008 buf_shift_en  output  1  shift enable to the 3-line image buffer.
REQ-009 pixel_edge  output  1  marks an accepted pixel at column 0; feeds the buffer edge bit.
REQ-010 window_valid  output  1  the buffer 3x3 matrix holds a full interior window.
REQ-011 win_col, win_row  output  CNT_WIDTH each  centre coordinates of the current window.
REQ-012 busy  output  1  high in FILL or RUN.
REQ-013 frame_done  output  1  one-cycle pulse when the frame completes.
REQ-014 drop_cnt  output  16  count of dropped pixels; present only with DROP_CNT_EN.

Function
REQ-015 The FSM SHALL have four states: IDLE, FILL (rows 0-1), RUN (rows 2..IMG_HEIGHT-1) and DONE.
REQ-016 IDLE->FILL on frame_start; FILL->RUN on acceptance of pixel (1, IMG_WIDTH-1); RUN->DONE on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1); DONE->IDLE after exactly one cycle.
REQ-017 A pixel is accepted when pixel_valid=1 and the state is FILL or RUN.
REQ-018 buf_shift_en SHALL be combinational and equal to pixel acceptance; pixel_valid in IDLE or DONE SHALL be ignored.
REQ-019 pixel_edge SHALL be combinational: buf_shift_en AND col==0.
REQ-020 On each accepted pixel, col SHALL increment; at IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment; counters hold when no pixel is accepted.
REQ-021 window_valid SHALL be a register set one cycle after acceptance of pixel (r,c) when r>=2 and c>=2, and cleared otherwise.
REQ-022 win_row/win_col SHALL be registered with window_valid as (r-1, c-1); they hold their values while window_valid=0.
REQ-023 A full frame SHALL yield exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) window_valid pulses; no border windows.
REQ-024 frame_done SHALL pulse in the DONE cycle, which is one cycle after the last pixel is accepted.
REQ-025 frame_start in any state SHALL zero col, row and window_valid, and enter FILL (this aborts a frame in progress).
REQ-026 When frame_start and pixel_valid are high in the same cycle, that pixel SHALL be accepted as (0,0).
REQ-027 Gaps in pixel_valid SHALL stall all counters and outputs without loss.

Reset
REQ-028 On rst, the block SHALL enter IDLE.
REQ-029 On rst, the counters, window_valid, win_row, win_col, frame_done and drop_cnt SHALL be 0.
REQ-030 Reset mid-frame SHALL abandon the frame; a frame_start is required to resume.

Configuration
REQ-031 With DROP_CNT_EN defined:
- drop_cnt SHALL increment on each pixel_valid seen in IDLE or DONE.
- drop_cnt SHALL saturate at 16'hFFFF.
- drop_cnt SHALL clear only on rst.
REQ-032 Without DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, FILL, RUN, DONE) and the default IMG_WIDTH and IMG_HEIGHT constants.
REQ-034 A sub-module pix_counter (column/row counter with wrap) SHALL be instantiated once.

Verification (IMG_WIDTH=8, IMG_HEIGHT=4)
REQ-035 Scenario: frame_start, then 32 back-to-back valid pixels.
- Response: exactly 12 window_valid pulses.
- Response: first window at (1,1), one cycle after pixel 18 (0-based index).
- Response: frame_done one cycle after pixel 31.
REQ-036 Scenario: pixel_valid toggled 1010... over a full frame.
- Response: the same 12 windows and coordinates as REQ-035.
- Response: buf_shift_en high only on valid cycles.
REQ-037 Scenario: frame_start asserted after 13 pixels.
- Response: counters restart at 0.
- Response: the next 32 pixels produce 12 windows and one frame_done.
REQ-038 Scenario: frame_start and pixel_valid high in the same cycle.
- Response: pixel_edge=1 on that cycle.
- Response: the pixel is counted as (0,0).
REQ-039 Scenario: 5 pixels sent while IDLE.
- Response: buf_shift_en stays 0.
- Response: drop_cnt=5 with DROP_CNT_EN; port absent without it.
REQ-040 Scenario: rst asserted after 20 pixels.
- Response: immediate return to IDLE with all outputs 0.
- Response: further pixels are ignored until frame_start.
